// File: rtl/nap_countdown_ctrl.sv
// rtl/nap_countdown_ctrl.sv - nap timer sequencer: setter gating, BCD countdown, timed alarm
// All outputs registered; prescaler and alarm counter share the tick strobe.
module nap_countdown_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_done,
  input  logic [3:0] set_one_sec,
  input  logic [3:0] set_ten_sec,
  input  logic [3:0] set_one_min,
  input  logic       pause_key,
  input  logic       stop_key,
  output logic       setter_en,
  output logic [3:0] cnt_one_sec,
  output logic [3:0] cnt_ten_sec,
  output logic [3:0] cnt_one_min,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [AW-1:0] alarm_cnt_q;
  logic [3:0]    one_q, ten_q, min_q;
  logic          setter_en_q, running_q, alarm_q, done_q;

  logic          tick_d;
  logic [3:0]    ld_one_d, ld_ten_d, ld_min_d;
  logic          ld_zero_d;
  logic [3:0]    dec_one_d, dec_ten_d, dec_min_d;
  logic          dec_zero_d;
  logic [PW-1:0] presc_inc_d;

  always_comb begin
    tick_d      = (presc_q == PW'(TICK_DIV - 1));
    presc_inc_d = tick_d ? '0 : presc_q + PW'(1);

    ld_one_d  = (set_one_sec > 4'd9) ? 4'd9 : set_one_sec;
    ld_ten_d  = (set_ten_sec > 4'd5) ? 4'd5 : set_ten_sec;
    ld_min_d  = (set_one_min > 4'd9) ? 4'd9 : set_one_min;
    ld_zero_d = (ld_one_d == 4'd0) && (ld_ten_d == 4'd0) && (ld_min_d == 4'd0);

    // One BCD step with borrow rippling seconds-units -> tens -> minutes.
    dec_one_d = one_q;
    dec_ten_d = ten_q;
    dec_min_d = min_q;
    if (one_q != 4'd0) begin
      dec_one_d = one_q - 4'd1;
    end else begin
      dec_one_d = 4'd9;
      if (ten_q != 4'd0) begin
        dec_ten_d = ten_q - 4'd1;
      end else begin
        dec_ten_d = 4'd5;
        dec_min_d = min_q - 4'd1;
      end
    end
    dec_zero_d = (dec_one_d == 4'd0) && (dec_ten_d == 4'd0) && (dec_min_d == 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      one_q       <= 4'd0;
      ten_q       <= 4'd0;
      min_q       <= 4'd0;
      setter_en_q <= 1'b1;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      // Lags the state by one cycle so the setter sees a clean handover.
      setter_en_q <= (state_q == S_IDLE);
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (cfg_done) begin
            if (ld_zero_d) begin
              one_q <= 4'd0;
              ten_q <= 4'd0;
              min_q <= 4'd0;
            end else begin
              one_q     <= ld_one_d;
              ten_q     <= ld_ten_d;
              min_q     <= ld_min_d;
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop_key) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            one_q     <= 4'd0;
            ten_q     <= 4'd0;
            min_q     <= 4'd0;
          end else begin
            presc_q <= presc_inc_d;
            if (tick_d) begin
              one_q <= dec_one_d;
              ten_q <= dec_ten_d;
              min_q <= dec_min_d;
              if (dec_zero_d) begin
                state_q     <= S_ALARM;
                running_q   <= 1'b0;
                alarm_q     <= 1'b1;
                alarm_cnt_q <= '0;
                presc_q     <= '0;
              end else if (pause_key) begin
                state_q   <= S_PAUSE;
                running_q <= 1'b0;
              end
            end else if (pause_key) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (stop_key) begin
            state_q <= S_IDLE;
            one_q   <= 4'd0;
            ten_q   <= 4'd0;
            min_q   <= 4'd0;
          end else if (pause_key) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_ALARM: begin
          one_q <= 4'd0;
          ten_q <= 4'd0;
          min_q <= 4'd0;
          if (stop_key) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            presc_q <= presc_inc_d;
            if (tick_d) begin
              if (alarm_cnt_q == AW'(ALARM_SECS - 1)) begin
                state_q <= S_IDLE;
                alarm_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                alarm_cnt_q <= alarm_cnt_q + AW'(1);
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign setter_en   = setter_en_q;
  assign cnt_one_sec = one_q;
  assign cnt_ten_sec = ten_q;
  assign cnt_one_min = min_q;
  assign running     = running_q;
  assign alarm       = alarm_q;
  assign done        = done_q;

endmodule
